cache_read_controller: RTL and testbench
========================================

// Module: cache_read_controller
// PURPOSE
//  Control FSM that drives the cache/main-memory datapath (allMemories-style
//  control port). Walks NUM_ACCESSES consecutive word addresses from BASE_ADDR.
//  For each address it checks for a hit. On a miss it requests the 4-word
//  block from main memory and writes it into the cache.
//  It counts hits and raises done at the end. It is the initiator of the
//  C_* control handshake that the datapath answers.
// PARAMETERS
//  ADDR_W        15       word-address width (tag = addr[14:12])
//  BASE_ADDR     15'd1024 first address accessed
//  NUM_ACCESSES  8192     number of sequential accesses
//  CNT_W         14       width of hit_count / access counter (>= clog2(NUM_ACCESSES)+1)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous reset, active-low (0 = reset)
//  start            in   1       begin a run; sampled only in IDLE or DONE
//  cache_valid      in   1       valid bit of indexed line (combinational from address)
//  is_wanted_data   in   1       tag of indexed line == address[14:12]
//  main_mem_ready   in   1       main memory block data available
//  address          out  ADDR_W  current access address to datapath
//  C_write_cache    out  1       write mem_data into cache at address + C_offset
//  C_main_mem_miss  out  1       block request to main memory
//  C_offset         out  2       word offset within block during fill
//  hit_count        out  CNT_W   number of hits in current/last run
//  busy             out  1       high from start acceptance until DONE
//  done             out  1       level, high in DONE
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=IDLE; address=BASE_ADDR; C_write_cache=0;
//   C_main_mem_miss=0; C_offset=0; hit_count=0; access counter=0; busy=0; done=0.
//   Reset mid-run aborts immediately. No pending request survives.
//  All outputs are registered or decoded from state only; no input->output comb path.
//  Sequence of states:
//   IDLE      -> LOOKUP on start. Clear hit_count and access counter, set address=BASE_ADDR.
//   LOOKUP    1 cycle. hit = cache_valid & is_wanted_data.
//             On a hit, hit_count++ and go to NEXT. On a miss, go to MISS_WAIT.
//   MISS_WAIT C_main_mem_miss=1. Stay until main_mem_ready=1, then go to FILL with C_offset=0.
//   FILL      C_main_mem_miss=1, C_write_cache=1, one word per cycle, C_offset 0,1,2,3.
//             After offset 3, go to NEXT. The fill uses the block-aligned
//             address {address[14:2],2'b00}. Cache writes land at base+0..3.
//   NEXT      1 cycle. Access counter++. If counter==NUM_ACCESSES go to DONE,
//             else address++ and go to LOOKUP.
//   DONE      done=1, busy=0, hit_count frozen. start -> LOOKUP (new run, cleared).
//  Latency: a hit takes 2 cycles (LOOKUP+NEXT). A miss takes 2+W+4 cycles,
//   where W = MISS_WAIT cycles (min 1).
//  A miss fill is counted as a miss. The same address is not re-looked-up.
//  start while busy is ignored. main_mem_ready outside MISS_WAIT is ignored.
//  main_mem_ready is assumed to stay high through FILL (datapath guarantee).
//  address wraps modulo 2^ADDR_W. hit_count saturates at 2^CNT_W-1.
//  C_offset=0 whenever not in FILL.
// STRUCTURE
//  Shared package cache_pkg: state encoding localparams (S_IDLE..S_DONE, 3 bits),
//   BLOCK_WORDS=4, OFFSET_W=2, TAG_MSB/TAG_LSB=14/12.
//  Sub-module: cache_access_counter (address register + access counter + saturating
//   hit counter, with clr/inc enables). The top contains the FSM and output decode.
// TESTING  (bench models cache tags plus main memory with programmable ready delay)
//  1. rst=0 for 2 cycles mid-FILL -> next cycle all outputs at reset values, state IDLE.
//  2. NUM_ACCESSES=4, all hits -> done after 8 cycles, hit_count=4, no C_main_mem_miss.
//  3. Cold cache, BASE_ADDR=1024, NUM_ACCESSES=4, ready delay 3
//     -> 1 miss, then 3 hits; hit_count=3.
//     C_write_cache high 4 cycles with C_offset 0,1,2,3.
//  4. Unaligned BASE_ADDR=1026, NUM_ACCESSES=4 -> misses at 1026 and 1028.
//     Fills target 1024..1027 and 1028..1031; hit_count=2.
//  5. Tag conflict: addresses 0x0000 then 0x1000 alternate (same index)
//     -> every access misses, hit_count=0.
//  6. start pulsed during LOOKUP/FILL -> ignored.
//     After DONE, start -> hit_count clears to 0, address=BASE_ADDR.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache read controller: FSM state encoding and
// block/tag geometry of the word address.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_WAIT = 3'd2,
    S_FILL      = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 2;
  localparam int TAG_MSB     = 14;
  localparam int TAG_LSB     = 12;

endpackage

// File: rtl/cache_access_counter.sv
// Address register, access counter and saturating hit counter.
// clr restarts a run; the increments are one-cycle enables from the FSM.
module cache_access_counter #(
  parameter int               ADDR_W    = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 15'd1024,
  parameter int               CNT_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              addr_inc,
  input  logic              cnt_inc,
  input  logic              hit_inc,
  output logic [ADDR_W-1:0] address,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  hit_count
);

  // Address wraps naturally at 2^ADDR_W; hit counter holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      address   <= BASE_ADDR;
      count     <= '0;
      hit_count <= '0;
    end else begin
      if (addr_inc) address <= address + 1'b1;
      if (cnt_inc)  count   <= count + 1'b1;
      if (hit_inc && (hit_count != {CNT_W{1'b1}})) hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_read_controller.sv
// Control FSM walking sequential word addresses: look up each address, on a
// miss request the 4-word block from main memory and write it into the cache.
// Outputs are flops or state-only decodes; no input reaches an output
// combinationally.
module cache_read_controller
  import cache_pkg::*;
#(
  parameter int               ADDR_W       = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 15'd1024,
  parameter int               NUM_ACCESSES = 8192,
  parameter int               CNT_W        = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cache_valid,
  input  logic                is_wanted_data,
  input  logic                main_mem_ready,
  output logic [ADDR_W-1:0]   address,
  output logic                C_write_cache,
  output logic                C_main_mem_miss,
  output logic [OFFSET_W-1:0] C_offset,
  output logic [CNT_W-1:0]    hit_count,
  output logic                busy,
  output logic                done
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    count;
  logic                clr, addr_inc, cnt_inc, hit_inc, last;

  assign last     = (count == CNT_W'(NUM_ACCESSES - 1));
  assign clr      = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign hit_inc  = (state == S_LOOKUP) && cache_valid && is_wanted_data;
  assign cnt_inc  = (state == S_NEXT);
  assign addr_inc = (state == S_NEXT) && !last;

  cache_access_counter #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .addr_inc  (addr_inc),
    .cnt_inc   (cnt_inc),
    .hit_inc   (hit_inc),
    .address   (addr_q),
    .count     (count),
    .hit_count (hit_count)
  );

  // During a fill the datapath writes at address + C_offset, so present the
  // block-aligned base; the unaligned address is kept for the next access.
  assign address = (state == S_FILL) ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}}
                                     : addr_q;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOOKUP;
      S_LOOKUP:       state_nxt = (cache_valid && is_wanted_data) ? S_NEXT : S_MISS_WAIT;
      S_MISS_WAIT:    if (main_mem_ready) state_nxt = S_FILL;
      S_FILL:         if (C_offset == OFFSET_W'(BLOCK_WORDS - 1)) state_nxt = S_NEXT;
      S_NEXT:         state_nxt = last ? S_DONE : S_LOOKUP;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State register with control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      C_write_cache   <= 1'b0;
      C_main_mem_miss <= 1'b0;
      C_offset        <= '0;
    end else begin
      state           <= state_nxt;
      busy            <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done            <= (state_nxt == S_DONE);
      C_write_cache   <= (state_nxt == S_FILL);
      C_main_mem_miss <= (state_nxt == S_MISS_WAIT) || (state_nxt == S_FILL);
      if (state_nxt == S_FILL && state == S_FILL) C_offset <= C_offset + 1'b1;
      else                                        C_offset <= '0;
    end
  end

endmodule

// File: tb/tb_cache_read_controller.sv
// Randomized bench: models the cache tag store and a main memory with a
// programmable ready delay. A reference model predicts every cache write and
// the per-run result; a monitor compares them against the DUT.
module tb_cache_read_controller;
  import cache_pkg::*;

  localparam int          ADDR_W = 15;
  localparam logic [14:0] BASE   = 15'd1026;
  localparam int          N      = 4;
  localparam int          CNT_W  = 14;

  logic              clk, rst, start, cache_valid, is_wanted_data, main_mem_ready;
  logic [ADDR_W-1:0] address;
  logic              C_write_cache, C_main_mem_miss, busy, done;
  logic [1:0]        C_offset;
  logic [CNT_W-1:0]  hit_count;

  cache_read_controller #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_ACCESSES(N), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cache_valid(cache_valid),
    .is_wanted_data(is_wanted_data), .main_mem_ready(main_mem_ready),
    .address(address), .C_write_cache(C_write_cache),
    .C_main_mem_miss(C_main_mem_miss), .C_offset(C_offset),
    .hit_count(hit_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath cache model: index = addr[11:0], tag = addr[14:12]
  logic [2:0] tag_arr [4096];
  logic       vld_arr [4096];
  logic [2:0] m_tag   [4096];
  logic       m_vld   [4096];
  assign cache_valid    = vld_arr[address[11:0]];
  assign is_wanted_data = (tag_arr[address[11:0]] == address[TAG_MSB:TAG_LSB]);

  typedef struct { logic [14:0] waddr; logic [1:0] off; } wr_t;
  typedef struct { int hits; int misses; int cycles; } run_t;
  wr_t  wq[$];
  run_t rq[$];

  int n_chk = 0, n_pass = 0;
  int delay = 1;
  bit conflict = 0, glitch = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: replay the access walk on a copy of the cache contents.
  task automatic model_run();
    int hits = 0, misses = 0, cyc = 0, w;
    logic [14:0] a, b;
    wr_t  wr;
    run_t rr;
    m_tag = tag_arr;
    m_vld = vld_arr;
    w = (delay < 1) ? 1 : delay;
    for (int i = 0; i < N; i++) begin
      a = BASE + 15'(i);
      if (m_vld[a[11:0]] && m_tag[a[11:0]] == a[TAG_MSB:TAG_LSB]) begin
        hits++; cyc += 2;
      end else begin
        misses++; cyc += 2 + w + BLOCK_WORDS;
        b = a & ~15'd3;
        for (int o = 0; o < BLOCK_WORDS; o++) begin
          wr.waddr = b + 15'(o);
          wr.off   = 2'(o);
          wq.push_back(wr);
          m_vld[wr.waddr[11:0]] = 1'b1;
          m_tag[wr.waddr[11:0]] = conflict ? (a[TAG_MSB:TAG_LSB] ^ 3'd1) : a[TAG_MSB:TAG_LSB];
        end
      end
    end
    rr.hits = hits; rr.misses = misses; rr.cycles = cyc;
    rq.push_back(rr);
  endtask

  // Main memory: ready after `delay` miss-wait cycles, held through the fill.
  int wcnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      main_mem_ready = 1'b0; wcnt = 0;
    end else if (C_main_mem_miss && !C_write_cache) begin
      wcnt++;
      main_mem_ready = (wcnt >= delay);
    end else if (!C_main_mem_miss) begin
      wcnt = 0;
      main_mem_ready = glitch ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Monitor: scores writes and run completions, applies writes to the cache.
  logic prev_busy = 0, prev_done = 0, prev_miss = 0;
  int   cyc = 0, miss_cnt = 0;
  always @(negedge clk) begin
    wr_t  e;
    run_t r;
    logic [14:0] wa;
    if (rst) begin
      if (busy && !prev_busy) begin cyc = 1; miss_cnt = 0; end
      else if (busy) cyc++;
      if (C_main_mem_miss && !prev_miss) miss_cnt++;
      if (C_write_cache) begin
        wa = address + 15'(C_offset);
        if (wq.size() == 0) chk("unexpected_write", int'(wa), -1);
        else begin
          e = wq.pop_front();
          chk("write_addr", int'(wa), int'(e.waddr));
          chk("write_off", int'(C_offset), int'(e.off));
        end
        vld_arr[wa[11:0]] = 1'b1;
        tag_arr[wa[11:0]] = conflict ? (wa[TAG_MSB:TAG_LSB] ^ 3'd1) : wa[TAG_MSB:TAG_LSB];
      end else chk("offset_idle", int'(C_offset), 0);
      if (done && !prev_done) begin
        if (rq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          r = rq.pop_front();
          chk("hit_count", int'(hit_count), r.hits);
          chk("miss_count", miss_cnt, r.misses);
          chk("run_cycles", cyc, r.cycles);
          chk("writes_drained", wq.size(), 0);
        end
      end
    end
    prev_busy = rst && busy;
    prev_done = rst && done;
    prev_miss = rst && C_main_mem_miss;
  end

  task automatic check_reset_vals();
    chk("rst_address", int'(address), int'(BASE));
    chk("rst_write", int'(C_write_cache), 0);
    chk("rst_miss", int'(C_main_mem_miss), 0);
    chk("rst_offset", int'(C_offset), 0);
    chk("rst_hits", int'(hit_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
  endtask

  task automatic invalidate_region();
    for (int a = 1020; a < 1036; a++) vld_arr[a] = 1'b0;
  endtask

  task automatic run(input int d, input bit conf, input bit glt);
    delay = d; conflict = conf; glitch = glt;
    model_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_address", int'(address), int'(BASE));
    chk("start_hits", int'(hit_count), 0);
    chk("start_busy", int'(busy), 1);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      start = glt && busy && ($urandom % 3 == 0);
    end
    start = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [14:0] a;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 4096; i++) begin vld_arr[i] = 1'b0; tag_arr[i] = 3'd0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b1;

    // reset held two cycles in the middle of a fill
    delay = 2; conflict = 0; glitch = 0;
    model_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50 && !C_write_cache; k++) @(negedge clk);
    chk("reached_fill", int'(C_write_cache), 1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_vals();
    @(posedge clk); @(negedge clk);
    wq.delete(); rq.delete();
    rst = 1'b1;

    // all hits
    for (int i = 0; i < N; i++) begin
      a = BASE + 15'(i);
      vld_arr[a[11:0]] = 1'b1; tag_arr[a[11:0]] = a[TAG_MSB:TAG_LSB];
    end
    run(2, 0, 0);

    // cold cache, unaligned base: misses at 1026 and 1028
    invalidate_region();
    run(3, 0, 0);

    // tag conflict: each filled line is stolen by the other tag
    invalidate_region();
    run(1, 1, 0);

    // random contents, delays, stray start and ready pulses
    for (int r = 0; r < 8; r++) begin
      for (int i = 1020; i < 1036; i++) begin
        a = 15'(i);
        vld_arr[i] = 1'($urandom % 2);
        tag_arr[i] = ($urandom % 2 == 0) ? a[TAG_MSB:TAG_LSB] : 3'($urandom);
      end
      run($urandom_range(0, 4), 0, 1);
    end

    chk("queues_empty", wq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
